rom_load_ctrl: RTL and testbench

ROM_LOAD_CTRL -- requirements
Module: rom_load_ctrl

---
 rtl/rom_load_pkg.sv | 21 ++
 rtl/rom_load_ctrl_if.sv | 38 +++
 rtl/rom_load_hold.sv | 36 +++
 rtl/rom_load_ctrl.sv | 178 +++++++++++++++++
 tb/tb_rom_load_ctrl.sv | 291 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/rom_load_pkg.sv
// Shared types and constants for the ROM download controller.
package rom_load_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WR      = 2'd1,
    ST_RD_ADDR = 2'd2,
    ST_RD_DATA = 2'd3
  } state_t;

  localparam logic [7:0] IDX_ROM   = 8'd0;
  localparam logic [7:0] IDX_MOD   = 8'd1;
  localparam logic [7:0] IDX_DIP   = 8'd254;
  localparam logic [7:0] MOD_UNSET = 8'hFF;

  // True when a download byte address falls inside the ROM window.
  function automatic logic addr_in_rom(input logic [24:0] a, input int aw);
    return ((a >> aw) == 25'd0);
  endfunction

endpackage

// File: rtl/rom_load_ctrl_if.sv
// Bus bundle between the HPS download stream, CPU read port, BRAM port and board controls.
interface rom_load_ctrl_if #(
  parameter int ROM_AW = 17
);
  logic              ioctl_download;
  logic              ioctl_wr;
  logic [7:0]        ioctl_index;
  logic [24:0]       ioctl_addr;
  logic [7:0]        ioctl_dout;
  logic              ioctl_wait;
  logic              cpu_req;
  logic [ROM_AW-1:0] cpu_addr;
  logic              cpu_ack;
  logic [7:0]        cpu_data;
  logic [ROM_AW-1:0] mem_addr;
  logic [7:0]        mem_din;
  logic              mem_we;
  logic [7:0]        mem_dout;
  logic              sw_we;
  logic [2:0]        sw_idx;
  logic [7:0]        sw_data;
  logic [7:0]        mod;
  logic              core_reset;

  modport slave (
    input  ioctl_download, ioctl_wr, ioctl_index, ioctl_addr, ioctl_dout,
    input  cpu_req, cpu_addr, mem_dout,
    output ioctl_wait, cpu_ack, cpu_data, mem_addr, mem_din, mem_we,
    output sw_we, sw_idx, sw_data, mod, core_reset
  );

  modport master (
    output ioctl_download, ioctl_wr, ioctl_index, ioctl_addr, ioctl_dout,
    output cpu_req, cpu_addr, mem_dout,
    input  ioctl_wait, cpu_ack, cpu_data, mem_addr, mem_din, mem_we,
    input  sw_we, sw_idx, sw_data, mod, core_reset
  );
endinterface

// File: rtl/rom_load_hold.sv
// Holds the board in reset during a ROM download and for HOLD_CYCLES after it ends.
module rom_load_hold #(
  parameter int HOLD_CYCLES = 1024
) (
  input  logic clk_sys,
  input  logic reset_n,
  input  logic i_rom_dl,
  output logic o_core_reset
);

  localparam int CNT_W = $clog2(HOLD_CYCLES + 1);

  logic [CNT_W-1:0] r_cnt;
  logic             r_hold;

  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      r_hold <= 1'b1;
      r_cnt  <= '0;
    end else if (i_rom_dl) begin
      r_hold <= 1'b1;
      r_cnt  <= '0;
    end else if (r_hold) begin
      if (r_cnt == CNT_W'(HOLD_CYCLES - 1)) begin
        r_hold <= 1'b0;
        r_cnt  <= '0;
      end else begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  // Asserted in the same cycle a download starts, not one cycle later.
  assign o_core_reset = r_hold | i_rom_dl;

endmodule

// File: rtl/rom_load_ctrl.sv
// ROM download / CPU read arbiter over one shared BRAM port, plus MOD and DIP capture.
// Optional: define ROM_LOAD_CHECKSUM_EN to add the rom_sum / rom_sum_valid download checksum.
module rom_load_ctrl
  import rom_load_pkg::*;
#(
  parameter int ROM_AW      = 17,
  parameter int HOLD_CYCLES = 1024
) (
  input  logic            clk_sys,
  input  logic            reset_n,
`ifdef ROM_LOAD_CHECKSUM_EN
  output logic [15:0]     rom_sum,
  output logic            rom_sum_valid,
`endif
  rom_load_ctrl_if.slave  bus
);

  state_t            r_state;
  state_t            w_state_nxt;
  logic              r_buf_full;
  logic [ROM_AW-1:0] r_buf_addr;
  logic [7:0]        r_buf_data;
  logic              r_cpu_ack;
  logic [7:0]        r_cpu_data;
  logic              r_sw_we;
  logic [2:0]        r_sw_idx;
  logic [7:0]        r_sw_data;
  logic [7:0]        r_mod;

  logic              w_rom_dl;
  logic              w_accept;
  logic              w_mod_wr;
  logic              w_dip_wr;
  logic              w_mem_we;
  logic [ROM_AW-1:0] w_mem_addr;
  logic [7:0]        w_mem_din;
  logic              w_buf_clr;
  logic              w_rd_done;
  logic              w_core_reset;

  assign w_rom_dl = bus.ioctl_download && (bus.ioctl_index == IDX_ROM);
  // A strobe while the buffer is full is dropped here rather than overwriting it.
  assign w_accept = w_rom_dl && bus.ioctl_wr && !r_buf_full &&
                    addr_in_rom(bus.ioctl_addr, ROM_AW);
  assign w_mod_wr = bus.ioctl_download && bus.ioctl_wr && (bus.ioctl_index == IDX_MOD);
  assign w_dip_wr = bus.ioctl_download && bus.ioctl_wr && (bus.ioctl_index == IDX_DIP) &&
                    (bus.ioctl_addr[24:3] == 22'd0);

  always_ff @(posedge clk_sys) begin
    if (!reset_n) r_state <= ST_IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (r_buf_full)                 w_state_nxt = ST_WR;
        else if (bus.cpu_req && !w_rom_dl) w_state_nxt = ST_RD_ADDR;
      end
      ST_WR:      w_state_nxt = ST_IDLE;
      ST_RD_ADDR: w_state_nxt = ST_RD_DATA;
      ST_RD_DATA: w_state_nxt = ST_IDLE;
      default:    w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    w_mem_we   = 1'b0;
    w_mem_addr = '0;
    w_mem_din  = 8'd0;
    w_buf_clr  = 1'b0;
    w_rd_done  = 1'b0;
    case (r_state)
      ST_WR: begin
        w_mem_we   = 1'b1;
        w_mem_addr = r_buf_addr;
        w_mem_din  = r_buf_data;
        w_buf_clr  = 1'b1;
      end
      ST_RD_ADDR: w_mem_addr = bus.cpu_addr;
      ST_RD_DATA: begin
        w_mem_addr = bus.cpu_addr;
        w_rd_done  = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_sys) begin
    if (!reset_n)       r_buf_full <= 1'b0;
    else if (w_accept)  r_buf_full <= 1'b1;
    else if (w_buf_clr) r_buf_full <= 1'b0;
  end

  always_ff @(posedge clk_sys) begin
    if (w_accept) begin
      r_buf_addr <= bus.ioctl_addr[ROM_AW-1:0];
      r_buf_data <= bus.ioctl_dout;
    end
  end

  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      r_cpu_ack  <= 1'b0;
      r_cpu_data <= 8'd0;
    end else begin
      r_cpu_ack <= w_rd_done;
      if (w_rd_done) r_cpu_data <= bus.mem_dout;
    end
  end

  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      r_sw_we <= 1'b0;
      r_mod   <= MOD_UNSET;
    end else begin
      r_sw_we <= w_dip_wr;
      if (w_mod_wr) r_mod <= bus.ioctl_dout;
    end
  end

  always_ff @(posedge clk_sys) begin
    if (w_dip_wr) begin
      r_sw_idx  <= bus.ioctl_addr[2:0];
      r_sw_data <= bus.ioctl_dout;
    end
  end

  rom_load_hold #(
    .HOLD_CYCLES (HOLD_CYCLES)
  ) u_hold (
    .clk_sys      (clk_sys),
    .reset_n      (reset_n),
    .i_rom_dl     (w_rom_dl),
    .o_core_reset (w_core_reset)
  );

`ifdef ROM_LOAD_CHECKSUM_EN
  logic        r_rom_dl_q;
  logic [15:0] r_sum;
  logic        r_sum_valid;

  // Sum restarts on the first cycle of a download; valid covers the gap between downloads.
  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      r_rom_dl_q  <= 1'b0;
      r_sum       <= 16'd0;
      r_sum_valid <= 1'b0;
    end else begin
      r_rom_dl_q <= w_rom_dl;
      if (w_rom_dl && !r_rom_dl_q) begin
        r_sum       <= w_accept ? {8'h00, bus.ioctl_dout} : 16'd0;
        r_sum_valid <= 1'b0;
      end else begin
        if (w_accept) r_sum <= r_sum + {8'h00, bus.ioctl_dout};
        if (!w_rom_dl && r_rom_dl_q) r_sum_valid <= 1'b1;
      end
    end
  end

  assign rom_sum       = r_sum;
  assign rom_sum_valid = r_sum_valid;
`endif

  assign bus.ioctl_wait = r_buf_full;
  assign bus.cpu_ack    = r_cpu_ack;
  assign bus.cpu_data   = r_cpu_data;
  assign bus.mem_addr   = w_mem_addr;
  assign bus.mem_din    = w_mem_din;
  assign bus.mem_we     = w_mem_we;
  assign bus.sw_we      = r_sw_we;
  assign bus.sw_idx     = r_sw_idx;
  assign bus.sw_data    = r_sw_data;
  assign bus.mod        = r_mod;
  assign bus.core_reset = w_core_reset;

endmodule

// File: tb/tb_rom_load_ctrl.sv
// Scoreboard bench for rom_load_ctrl: BRAM model, HPS download driver, CPU reader.
module tb_rom_load_ctrl;

  localparam int AW = 17;
  localparam int H  = 1024;

  logic clk;
  logic rst_n;

  rom_load_ctrl_if #(.ROM_AW(AW)) bus();

`ifdef ROM_LOAD_CHECKSUM_EN
  logic [15:0] rom_sum;
  logic        rom_sum_valid;
`endif

  rom_load_ctrl #(
    .ROM_AW      (AW),
    .HOLD_CYCLES (H)
  ) dut (
    .clk_sys       (clk),
    .reset_n       (rst_n),
`ifdef ROM_LOAD_CHECKSUM_EN
    .rom_sum       (rom_sum),
    .rom_sum_valid (rom_sum_valid),
`endif
    .bus           (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [7:0] rom [0:(1<<AW)-1];

  always @(posedge clk) begin
    if (!rst_n) rom[17'h01234] <= 8'h5A;
    else if (bus.mem_we) rom[bus.mem_addr] <= bus.mem_din;
    bus.mem_dout <= rom[bus.mem_addr];
  end

  typedef struct packed { logic [AW-1:0] a; logic [7:0] d; } wr_t;
  typedef struct packed { logic [2:0] i; logic [7:0] d; } sw_t;

  wr_t        wq[$];
  logic [7:0] rq[$];
  sw_t        sq[$];
  wr_t        e_wr;
  sw_t        e_sw;
  logic [7:0] e_rd;
  int         n_vec, n_err, n_we, n_sw;

  task automatic chk_vec(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic hps_wr(input logic [24:0] a, input logic [7:0] d);
    int g;
    g = 0;
    while (bus.ioctl_wait && g < 50) begin
      tick();
      g++;
    end
    if (g >= 50) chk_vec("wait_timeout", 32'(bus.ioctl_wait), 32'd0);
    bus.ioctl_wr   = 1'b1;
    bus.ioctl_addr = a;
    bus.ioctl_dout = d;
    if (bus.ioctl_index == 8'd0 && a < 25'(1 << AW)) wq.push_back('{a: a[AW-1:0], d: d});
    if (bus.ioctl_index == 8'd254 && a[24:3] == 22'd0) sq.push_back('{i: a[2:0], d: d});
    tick();
    bus.ioctl_wr = 1'b0;
  endtask

  task automatic do_read(input logic [AW-1:0] a, input logic [7:0] exp, output int lat);
    rq.push_back(exp);
    bus.cpu_addr = a;
    bus.cpu_req  = 1'b1;
    lat = 0;
    while (lat < 20) begin
      tick();
      lat++;
      if (bus.cpu_ack) break;
    end
    bus.cpu_req = 1'b0;
  endtask

  task automatic monitor();
    forever begin
      @(negedge clk);
      if (bus.mem_we) begin
        n_we++;
        if (wq.size() == 0) chk_vec("mem_we_unexpected", 32'd1, 32'd0);
        else begin
          e_wr = wq.pop_front();
          chk_vec("mem_addr", 32'(bus.mem_addr), 32'(e_wr.a));
          chk_vec("mem_din", 32'(bus.mem_din), 32'(e_wr.d));
        end
      end
      if (bus.cpu_ack) begin
        if (rq.size() == 0) chk_vec("cpu_ack_unexpected", 32'd1, 32'd0);
        else begin
          e_rd = rq.pop_front();
          chk_vec("cpu_data", 32'(bus.cpu_data), 32'(e_rd));
        end
      end
      if (bus.sw_we) begin
        n_sw++;
        if (sq.size() == 0) chk_vec("sw_we_unexpected", 32'd1, 32'd0);
        else begin
          e_sw = sq.pop_front();
          chk_vec("sw_idx", 32'(bus.sw_idx), 32'(e_sw.i));
          chk_vec("sw_data", 32'(bus.sw_data), 32'(e_sw.d));
        end
      end
    end
  endtask

  initial begin
    int lat;
    int acks;
    n_vec = 0; n_err = 0; n_we = 0; n_sw = 0;
    rst_n = 1'b0;
    bus.ioctl_download = 1'b0;
    bus.ioctl_wr       = 1'b0;
    bus.ioctl_index    = 8'd0;
    bus.ioctl_addr     = 25'd0;
    bus.ioctl_dout     = 8'd0;
    bus.cpu_req        = 1'b0;
    bus.cpu_addr       = '0;
    fork
      monitor();
    join_none
    repeat (3) tick();

    chk_vec("rst_wait", 32'(bus.ioctl_wait), 32'd0);
    chk_vec("rst_ack", 32'(bus.cpu_ack), 32'd0);
    chk_vec("rst_mem_we", 32'(bus.mem_we), 32'd0);
    chk_vec("rst_sw_we", 32'(bus.sw_we), 32'd0);
    chk_vec("rst_cpu_data", 32'(bus.cpu_data), 32'd0);
    chk_vec("rst_mem_addr", 32'(bus.mem_addr), 32'd0);
    chk_vec("rst_mod", 32'(bus.mod), 32'hFF);
    chk_vec("rst_core_reset", 32'(bus.core_reset), 32'd1);

    rst_n = 1'b1;
    repeat (H - 1) tick();
    chk_vec("hold_after_rst_hi", 32'(bus.core_reset), 32'd1);
    tick();
    chk_vec("hold_after_rst_lo", 32'(bus.core_reset), 32'd0);

    // Plain CPU read from idle.
    do_read(17'h01234, 8'h5A, lat);
    chk_vec("rd_latency", 32'(lat), 32'd3);
    tick();
    chk_vec("rd_ack_pulse", 32'(bus.cpu_ack), 32'd0);

    // Game-variant byte load; must not disturb core_reset.
    bus.ioctl_download = 1'b1;
    bus.ioctl_index    = 8'd1;
    hps_wr(25'd0, 8'h09);
    hps_wr(25'd5, 8'h04);
    tick();
    chk_vec("mod_value", 32'(bus.mod), 32'h04);
    chk_vec("mod_no_core_reset", 32'(bus.core_reset), 32'd0);
    bus.ioctl_download = 1'b0;
    tick();

    // 16-byte ROM download, then an out-of-window byte.
    bus.ioctl_download = 1'b1;
    bus.ioctl_index    = 8'd0;
    tick();
    chk_vec("dl_core_reset", 32'(bus.core_reset), 32'd1);
    for (int i = 0; i < 16; i++) hps_wr(25'(i), 8'hA0 + 8'(i));
    repeat (4) tick();
    hps_wr(25'h0020000, 8'h11);
    chk_vec("drop_no_stall", 32'(bus.ioctl_wait), 32'd0);
    repeat (4) tick();
    chk_vec("dl_we_count", 32'(n_we), 32'd16);
    chk_vec("dl_queue_empty", 32'(wq.size()), 32'd0);
    chk_vec("dl_core_reset_end", 32'(bus.core_reset), 32'd1);
    bus.ioctl_download = 1'b0;
    repeat (H - 1) tick();
    chk_vec("hold_after_dl_hi", 32'(bus.core_reset), 32'd1);
    tick();
    chk_vec("hold_after_dl_lo", 32'(bus.core_reset), 32'd0);

    // Download byte lands while a read sits in RD_ADDR.
    bus.cpu_addr = 17'h01234;
    bus.cpu_req  = 1'b1;
    rq.push_back(8'h5A);
    tick();
    bus.ioctl_download = 1'b1;
    bus.ioctl_index    = 8'd0;
    bus.ioctl_wr       = 1'b1;
    bus.ioctl_addr     = 25'h40;
    bus.ioctl_dout     = 8'h33;
    wq.push_back('{a: 17'h40, d: 8'h33});
    tick();
    bus.ioctl_wr = 1'b0;
    chk_vec("rdwr_wait_c2", 32'(bus.ioctl_wait), 32'd1);
    chk_vec("rdwr_ack_c2", 32'(bus.cpu_ack), 32'd0);
    tick();
    chk_vec("rdwr_wait_c3", 32'(bus.ioctl_wait), 32'd1);
    chk_vec("rdwr_ack_c3", 32'(bus.cpu_ack), 32'd1);
    bus.cpu_req = 1'b0;
    tick();
    chk_vec("rdwr_we_after_read", 32'(bus.mem_we), 32'd1);
    hps_wr(25'h41, 8'h34);
    repeat (4) tick();
    chk_vec("rdwr_queue_empty", 32'(wq.size()), 32'd0);

    // CPU read stalled for the length of the download.
    bus.cpu_addr = 17'h0;
    bus.cpu_req  = 1'b1;
    rq.push_back(8'hA0);
    acks = 0;
    repeat (10) begin
      tick();
      if (bus.cpu_ack) acks++;
    end
    chk_vec("stall_no_ack", 32'(acks), 32'd0);
    bus.ioctl_download = 1'b0;
    lat = 0;
    while (lat < 20) begin
      tick();
      lat++;
      if (bus.cpu_ack) break;
    end
    bus.cpu_req = 1'b0;
    chk_vec("stall_release_lat", 32'(lat), 32'd3);
    tick();

    // DIP switch bytes.
    bus.ioctl_download = 1'b1;
    bus.ioctl_index    = 8'd254;
    hps_wr(25'd3, 8'h7E);
    repeat (2) tick();
    hps_wr(25'd8, 8'h55);
    repeat (2) tick();
    bus.ioctl_download = 1'b0;
    chk_vec("dip_pulses", 32'(n_sw), 32'd1);

`ifdef ROM_LOAD_CHECKSUM_EN
    bus.ioctl_download = 1'b1;
    bus.ioctl_index    = 8'd0;
    tick();
    chk_vec("sum_valid_dl", 32'(rom_sum_valid), 32'd0);
    hps_wr(25'h100, 8'hFF);
    hps_wr(25'h101, 8'hFF);
    hps_wr(25'h102, 8'h02);
    repeat (4) tick();
    bus.ioctl_download = 1'b0;
    repeat (2) tick();
    chk_vec("sum_valid", 32'(rom_sum_valid), 32'd1);
    chk_vec("sum_value", 32'(rom_sum), 32'h0200);
`endif

    // Reset while a byte is buffered: it must never reach the BRAM.
    bus.ioctl_download = 1'b1;
    bus.ioctl_index    = 8'd0;
    bus.ioctl_wr       = 1'b1;
    bus.ioctl_addr     = 25'h50;
    bus.ioctl_dout     = 8'h99;
    tick();
    bus.ioctl_wr = 1'b0;
    chk_vec("abort_wait_set", 32'(bus.ioctl_wait), 32'd1);
    rst_n = 1'b0;
    tick();
    chk_vec("abort_wait_clr", 32'(bus.ioctl_wait), 32'd0);
    chk_vec("abort_mem_we", 32'(bus.mem_we), 32'd0);
    chk_vec("abort_mod", 32'(bus.mod), 32'hFF);
    rst_n = 1'b1;
    bus.ioctl_download = 1'b0;
    repeat (5) tick();

    chk_vec("final_wq", 32'(wq.size()), 32'd0);
    chk_vec("final_rq", 32'(rq.size()), 32'd0);
    chk_vec("final_sq", 32'(sq.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
